// File: rtl/sort_loader.sv
// Frame loader for the sorter: writes up to DEPTH bytes of a frame into sort memory,
// drops any overflow, then starts the sorter and waits for it to finish.
module sort_loader #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic          t_clk,
  input  logic          t_s_rst_n,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic [7:0]    t_n,
  output logic          t_s_go,
  input  logic          sort_done,
  output logic          ovf
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_GO    = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_wptr;
  logic            r_ready;
  logic            r_we;
  logic            r_go;
  logic            r_ovf;
  logic [AW-1:0]   r_addr;
  logic [7:0]      r_wdata;
  logic [7:0]      r_tn;

  logic            w_accept;
  logic            w_loading;
  logic            w_full;
  logic            w_done;
  logic            w_we_nxt;
  logic            w_go_nxt;
  logic            w_ready_nxt;
  logic            w_ovf_nxt;
  logic [AW-1:0]   w_wptr_nxt;
  logic [AW-1:0]   w_addr_nxt;
  logic [7:0]      w_wdata_nxt;
  logic [7:0]      w_tn_nxt;

  assign w_accept  = in_valid & r_ready;
  assign w_loading = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign w_full    = (r_wptr == AW'(DEPTH - 1));
  // The start-pulse cycle may already sit in WAIT; a done seen there is stale.
  assign w_done    = sort_done & ~r_go;

  // State register
  always_ff @(posedge t_clk or negedge t_s_rst_n) begin
    if (!t_s_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_LOAD: begin
        if (w_accept) begin
          if (in_last)     w_state_nxt = S_GO;
          else if (w_full) w_state_nxt = S_DRAIN;
          else             w_state_nxt = S_LOAD;
        end
      end
      S_DRAIN: if (w_accept && in_last) w_state_nxt = S_GO;
      S_GO:    w_state_nxt = S_WAIT;
      S_WAIT:  if (w_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    w_we_nxt    = w_accept & w_loading;
    // Loaded frames pulse after the final write; drained frames right after the last drop.
    w_go_nxt    = ((r_state == S_GO) && r_we) ||
                  ((r_state == S_DRAIN) && w_accept && in_last);
    w_ready_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_LOAD) ||
                  (w_state_nxt == S_DRAIN);
    w_ovf_nxt   = r_ovf;
    w_wptr_nxt  = r_wptr;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_tn_nxt    = r_tn;
    if (w_accept && (r_state == S_IDLE)) w_ovf_nxt = w_full & ~in_last;
    else if (w_accept && (r_state == S_LOAD) && w_full && !in_last) w_ovf_nxt = 1'b1;
    if (w_we_nxt) begin
      w_wptr_nxt  = r_wptr + AW'(1);
      w_addr_nxt  = r_wptr;
      w_wdata_nxt = in_data;
      if (in_last || w_full) w_tn_nxt = 8'(r_wptr) + 8'd1;
    end
    if ((r_state == S_WAIT) && w_done) w_wptr_nxt = '0;
  end

  // Registered outputs
  always_ff @(posedge t_clk or negedge t_s_rst_n) begin
    if (!t_s_rst_n) begin
      r_wptr  <= '0;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_go    <= 1'b0;
      r_ovf   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_tn    <= '0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_ready <= w_ready_nxt;
      r_we    <= w_we_nxt;
      r_go    <= w_go_nxt;
      r_ovf   <= w_ovf_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_tn    <= w_tn_nxt;
    end
  end

  assign in_ready  = r_ready;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign t_n       = r_tn;
  assign t_s_go    = r_go;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_sort_loader.sv
// Randomized bench for sort_loader: a frame-level model predicts writes, start pulse,
// count and overflow flag from the frame contents and the accept cycles.
module tb_sort_loader;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          t_clk;
  logic          t_s_rst_n;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_last;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    t_n;
  logic          t_s_go;
  logic          sort_done;
  logic          ovf;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  byte unsigned frame_q[$];

  sort_loader #(.DEPTH(DEPTH), .AW(AW)) u_dut (
    .t_clk     (t_clk),
    .t_s_rst_n (t_s_rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .t_n       (t_n),
    .t_s_go    (t_s_go),
    .sort_done (sort_done),
    .ovf       (ovf)
  );

  initial t_clk = 1'b0;
  always #5 t_clk = ~t_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge t_clk);
    #1;
    cyc++;
  endtask

  // Drives frame_q through the DUT (entered just after an edge with the loader idle),
  // then lets it sit in WAIT and releases it with sort_done.
  task automatic run_frame(input int gap_pct, input bit toggle, input int sd_pct);
    int  len    = frame_q.size();
    int  nw     = (len < DEPTH) ? len : DEPTH;
    int  idx    = 0;
    int  go_cyc = 32'h7fff_ffff;
    int  start  = cyc;
    int  n_wr   = 0;
    bit  done   = 1'b0;
    bit  rdy    = 1'b1;
    bit  phase  = 1'b1;
    bit  e_we   = 1'b0;
    int  e_addr = 0;
    int  e_data = 0;
    bit  v;
    bit  acc;
    while (cyc <= go_cyc) begin
      if (cyc - start > 4 * len + 40) begin
        check_eq("frame_timeout", 32'd0, 32'd1);
        break;
      end
      check_eq("mem_we", 32'(mem_we), 32'(e_we));
      if (e_we) begin
        n_wr++;
        check_eq("mem_addr", 32'(mem_addr), 32'(e_addr));
        check_eq("mem_wdata", 32'(mem_wdata), 32'(e_data));
      end
      check_eq("t_s_go", 32'(t_s_go), 32'(cyc == go_cyc));
      check_eq("in_ready", 32'(in_ready), 32'(rdy));
      if (cyc == go_cyc) begin
        check_eq("t_n_at_go", 32'(t_n), 32'(nw));
        check_eq("ovf_at_go", 32'(ovf), 32'(len > DEPTH));
      end
      if (!done && idx < len) v = toggle ? phase : (32'($urandom_range(99)) >= 32'(gap_pct));
      else                    v = 1'b0;
      phase     = ~phase;
      in_valid  = v;
      in_data   = v ? frame_q[idx] : 8'($urandom);
      in_last   = v ? (idx == len - 1) : 1'($urandom);
      sort_done = (32'($urandom_range(99)) < 32'(sd_pct));
      acc       = v && rdy;
      e_we      = acc && (idx < DEPTH);
      e_addr    = idx;
      e_data    = (idx < len) ? int'(frame_q[idx]) : 0;
      if (acc) begin
        if (idx == len - 1) begin
          done   = 1'b1;
          go_cyc = cyc + ((len <= DEPTH) ? 2 : 1);
        end
        idx++;
      end
      rdy = !done;
      tick();
    end
    check_eq("write_count", 32'(n_wr), 32'(nw));
    sort_done = 1'b0;
    repeat ($urandom_range(3)) begin
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      in_last  = 1'($urandom);
      tick();
      check_eq("wait_ready", 32'(in_ready), 32'd0);
      check_eq("wait_we", 32'(mem_we), 32'd0);
    end
    in_valid  = 1'b0;
    sort_done = 1'b1;
    tick();
    sort_done = 1'b0;
    check_eq("idle_ready", 32'(in_ready), 32'd1);
    check_eq("t_n_held", 32'(t_n), 32'(nw));
    check_eq("ovf_held", 32'(ovf), 32'(len > DEPTH));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'(in_ready), 32'd0);
    check_eq({tag, "_we"},    32'(mem_we), 32'd0);
    check_eq({tag, "_addr"},  32'(mem_addr), 32'd0);
    check_eq({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    check_eq({tag, "_t_n"},   32'(t_n), 32'd0);
    check_eq({tag, "_go"},    32'(t_s_go), 32'd0);
    check_eq({tag, "_ovf"},   32'(ovf), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge t_clk);
    @(negedge t_clk);
    t_s_rst_n = 1'b1;
    tick();
    check_eq("ready_after_reset", 32'(in_ready), 32'd1);
  endtask

  initial begin
    byte unsigned d[6];
    t_s_rst_n = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    in_last   = 1'b0;
    sort_done = 1'b0;
    #3;
    check_reset_outputs("rst0");
    release_reset();

    frame_q = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5};
    run_frame(0, 1'b0, 100);

    frame_q = '{8'hAA};
    run_frame(0, 1'b0, 0);

    frame_q.delete();
    for (int i = 0; i < 40; i++) frame_q.push_back(8'($urandom));
    run_frame(0, 1'b0, 20);

    frame_q.delete();
    for (int i = 0; i < 32; i++) frame_q.push_back(8'($urandom));
    run_frame(0, 1'b0, 20);

    frame_q.delete();
    for (int i = 0; i < 6; i++) frame_q.push_back(8'($urandom));
    run_frame(0, 1'b1, 10);

    // Abandon a 6-byte frame after three toggled beats
    for (int i = 0; i < 6; i++) d[i] = 8'($urandom);
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1;
      in_data  = d[j];
      in_last  = 1'b0;
      tick();
      check_eq("abort_we", 32'(mem_we), 32'd1);
      check_eq("abort_addr", 32'(mem_addr), 32'(j));
      check_eq("abort_wdata", 32'(mem_wdata), 32'(d[j]));
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      in_last  = 1'b1;
      tick();
      check_eq("abort_gap_we", 32'(mem_we), 32'd0);
    end
    in_last   = 1'b0;
    t_s_rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    release_reset();
    repeat (4) begin
      tick();
      check_eq("no_go_after_reset", 32'(t_s_go), 32'd0);
      check_eq("no_we_after_reset", 32'(mem_we), 32'd0);
    end

    frame_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(30, 1'b0, 10);

    for (int f = 0; f < 15; f++) begin
      int len = $urandom_range(1, 45);
      frame_q.delete();
      for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
      run_frame($urandom_range(0, 60), 1'b0, 10);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sort_loader.md
SORT_LOADER -- requirements
Module: sort_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32, giving the number of sort-memory entries.
REQ-002 The block SHALL have parameter AW, default 5, giving the memory address width; it SHALL satisfy 2^AW = DEPTH.
REQ-003 The block SHALL have port t_clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port t_s_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream byte on in_data is valid.
REQ-006 The block SHALL have port in_data, input, 8 bits: the upstream data byte.
REQ-007 The block SHALL have port in_last, input, 1 bit: the current byte is the last byte of its frame.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-009 The block SHALL have port mem_we, output, 1 bit: sort-memory write strobe.
REQ-010 The block SHALL have port mem_addr, output, AW bits: sort-memory write address.
REQ-011 The block SHALL have port mem_wdata, output, 8 bits: sort-memory write data.
REQ-012 The block SHALL have port t_n, output, 8 bits: the element count handed to the sorter.
REQ-013 The block SHALL have port t_s_go, output, 1 bit: one-cycle sort start pulse.
REQ-014 The block SHALL have port sort_done, input, 1 bit: one-cycle sorter-finished pulse.
REQ-015 The block SHALL have port ovf, output, 1 bit: the last frame was truncated at DEPTH entries.

Function
REQ-016 A byte SHALL be accepted only on a cycle where in_valid=1 and in_ready=1.
REQ-017 The FSM SHALL have exactly five states: IDLE, LOAD, DRAIN, GO, WAIT.
REQ-018 in_ready SHALL be 1 in IDLE, LOAD and DRAIN, and 0 in GO and WAIT; it SHALL be a registered or pure state decode, with no path from in_valid.
REQ-019 For each byte accepted in IDLE or LOAD, the block SHALL assert mem_we=1 for exactly one cycle, in the cycle after acceptance.
REQ-020 In that write cycle, mem_addr SHALL equal the write pointer value at acceptance time and mem_wdata SHALL equal the accepted byte; mem_we SHALL be 0 in all other cycles.
REQ-021 The write pointer SHALL be 0 on entry to IDLE and SHALL increment by 1 per accepted-and-written byte.
REQ-022 IDLE -> LOAD SHALL occur on an accepted byte with in_last=0 that is not byte number DEPTH.
REQ-023 IDLE or LOAD -> GO SHALL occur on an accepted byte with in_last=1; this byte SHALL be written.
REQ-024 IDLE or LOAD -> DRAIN SHALL occur when the accepted byte is byte number DEPTH and in_last=0; that byte SHALL be written, and ovf SHALL be set to 1.
REQ-025 If byte number DEPTH arrives with in_last=1, the block SHALL go to GO with ovf=0.
REQ-026 In DRAIN, bytes SHALL be accepted and discarded with no memory write; DRAIN -> GO SHALL occur on an accepted byte with in_last=1.
REQ-027 In GO, the block SHALL assert t_s_go=1 for exactly one cycle, which is the cycle after the final mem_we (or after the final DRAIN acceptance); t_s_go SHALL be 0 in all other cycles.
REQ-028 The block SHALL then move to WAIT.
REQ-029 t_n SHALL equal the number of bytes written (1..DEPTH), zero-extended to 8 bits.
REQ-030 t_n SHALL be valid from the t_s_go cycle and SHALL be held until the next frame's first acceptance.
REQ-031 WAIT -> IDLE SHALL occur on sort_done=1, and the write pointer SHALL be cleared at that transition.
REQ-032 sort_done SHALL be ignored in every state except WAIT, including the t_s_go cycle itself.
REQ-033 ovf SHALL hold its value until the next frame's first acceptance, at which point it SHALL be cleared, unless that same byte sets it.
REQ-034 A zero-length frame SHALL NOT occur: every frame contains at least one byte, because in_last always travels with data.
REQ-035 in_data and in_last SHALL be ignored whenever in_valid=0.

Reset
REQ-036 Assertion of t_s_rst_n=0 SHALL immediately force the following, regardless of t_clk: state=IDLE, write pointer=0, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, t_n=0, t_s_go=0, ovf=0.
REQ-037 in_ready SHALL become 1 on the first rising edge after deassertion.
REQ-038 Reset mid-frame or in WAIT SHALL abandon the frame; memory contents are don't-care, and no t_s_go SHALL be issued for the abandoned frame.
REQ-039 Deassertion SHALL be synchronous to t_clk, handled by the integrating reset synchroniser.

Verification
REQ-040 The bench SHALL cover a 5-byte frame 9,3,7,1,5 (last on the byte 5) with valid held high -> mem_we on 5 consecutive cycles at addresses 0..4 with data 9,3,7,1,5; t_s_go one cycle later; t_n=5, ovf=0; in_ready=0 until sort_done.
REQ-041 The bench SHALL cover a single-byte frame 0xAA with last=1 -> one write at address 0; t_s_go the next cycle; t_n=1.
REQ-042 The bench SHALL cover a 40-byte frame -> 32 writes at addresses 0..31; bytes 33..40 dropped; t_s_go one cycle after byte 40 is accepted; t_n=32, ovf=1.
REQ-043 The bench SHALL cover exactly 32 bytes with last on byte 32 -> 32 writes; t_n=32, ovf=0.
REQ-044 The bench SHALL cover sort_done pulsed in LOAD and in GO -> no state change; pulsed in WAIT -> IDLE next cycle; a second frame then writes starting at address 0.
REQ-045 The bench SHALL cover valid toggled 1,0,1,0 mid-frame, and reset asserted after byte 3 of 6 -> writes only on accepted beats; after reset, outputs are 0 and there is no t_s_go; a new frame starts at address 0.
